// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-file read port between fetch bursts (req 0) and single reads (req 1).
// Accept->first beat valid in 2 cycles, one beat per 2 cycles; each beat is held until rsp_ready, which stalls the burst.
module regfile_read_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [3:0]        r0_len,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_ready,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_last,
    input  logic              rsp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_last_q, rsp_last_d;
    logic              gnt0, gnt1;

    // On a tie prio picks the winner; otherwise whichever requester is valid.
    always_comb begin
        gnt1 = r1_valid && (!r0_valid || prio_q);
        gnt0 = r0_valid && !gnt1;
    end

    assign r0_ready  = (state_q == IDLE) && gnt0 && !reset;
    assign r1_ready  = (state_q == IDLE) && gnt1 && !reset;
    assign rf_addr   = cur_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cur_addr_d  = cur_addr_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_last_d  = rsp_last_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    cur_addr_d = gnt1 ? r1_addr : r0_addr;
                    len_d      = gnt1 ? 4'd0 : r0_len;
                    id_d       = gnt1;
                    beat_cnt_d = 4'd0;
                    state_d    = READ;
                end
            end
            READ: begin
                rsp_data_d  = rf_data;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_last_d  = (beat_cnt_q == len_q);
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        prio_d  = ~id_q;
                        state_d = IDLE;
                    end else begin
                        // Address wraps naturally at 2^ADDR_W.
                        cur_addr_d = cur_addr_q + 1'b1;
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        state_d    = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cur_addr_q  <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Arbiter and sequencer for the single read port of the 16-bit × 1024-entry register-file storage in the instruction-fetch datapath. It shares that port between two requesters:
- requester 0: instruction fetch, which issues bursts of up to 16 consecutive addresses;
- requester 1: data/debug reads, single beat.

It uses round-robin arbitration, drives the storage read address, registers each read value and returns it on a valid/ready response channel tagged with the requester ID.

## Interface
Parameters:
- ADDR_W, 10, storage address width; address arithmetic is modulo 2^ADDR_W
- DATA_W, 16, storage word width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- r0_valid  in  1  fetch request valid; held until r0_ready
- r0_addr  in  ADDR_W  burst start address
- r0_len  in  4  burst beats minus one (0 gives 1 beat, 15 gives 16 beats)
- r0_ready  out  1  combinational accept strobe for requester 0
- r1_valid  in  1  single-beat request valid; held until r1_ready
- r1_addr  in  ADDR_W  read address
- r1_ready  out  1  combinational accept strobe for requester 1
- rf_addr  out  ADDR_W  registered read address to storage
- rf_data  in  DATA_W  combinational read value from storage
- rsp_valid  out  1  response beat valid
- rsp_data  out  DATA_W  registered read data
- rsp_id  out  1  0 = requester 0, 1 = requester 1
- rsp_last  out  1  final beat of the current transaction
- rsp_ready  in  1  response consumer accepts the beat
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM has three states: IDLE, READ, HOLD. Reset state is IDLE.
- Internal state:
  - prio (1 bit, reset 0): the preferred requester.
  - cur_addr: current read address.
  - len: latched burst length.
  - beat_cnt (4 bits): beats issued in the current transaction.
  - id: latched requester ID.
- IDLE:
  - Grant selection: if both requesters are valid, grant the requester equal to prio. Otherwise grant whichever one is valid.
  - Drive rX_ready=1 to the granted requester only, in that same cycle. rX_ready is never high outside IDLE.
  - On the accept edge:
    - latch cur_addr from the granted rX_addr;
    - latch len = r0_len for requester 0, 0 for requester 1;
    - latch id; set beat_cnt = 0;
    - go to READ.
- READ:
  - rf_addr = cur_addr (valid for this whole cycle).
  - On the edge:
    - rsp_data ← rf_data;
    - rsp_valid ← 1; rsp_id ← id;
    - rsp_last ← (beat_cnt == len);
    - go to HOLD.
- HOLD:
  - rsp_valid, rsp_data, rsp_id and rsp_last stay stable until rsp_ready=1.
  - On handshake with rsp_last=1: rsp_valid ← 0, prio ← ~id, go to IDLE.
  - On handshake with rsp_last=0: rsp_valid ← 0, cur_addr ← cur_addr+1 (1023 wraps to 0), beat_cnt ← beat_cnt+1, go to READ.
- rf_addr is driven from cur_addr in every state and holds its last value outside READ.
- Storage contents are sampled per beat; bursts are not atomic against storage updates.
- A requester that drops valid before ready is a protocol violation. The arbiter does not check for it.

## Timing
- Reset values: rf_addr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_last=0, busy=0, prio=0.
- r0_ready and r1_ready are forced to 0 while reset is high.
- Latency: an accept at edge T gives READ in cycle T+1 and rsp_valid=1 from cycle T+2.
- Throughput with rsp_ready held high: one beat every 2 cycles. A burst of L+1 beats shows its last rsp_valid at cycle T+2+2L.
- Back-pressure: every cycle of rsp_ready=0 in HOLD adds one cycle of stall. Outputs must not change during a stall.
- Next accept is possible in the cycle after the last-beat handshake (IDLE). Minimum spacing between accepts is 3 cycles for single-beat transactions.
- Fairness: after a completed transaction, the other requester wins the next tie.
- Reset mid-burst:
  - the burst is abandoned and no further beats are issued;
  - prio returns to 0;
  - the first accept after reset deasserts follows the IDLE rules.

## Test plan
- Single read: storage[5]=0xBEEF, r1_valid with r1_addr=5, rsp_ready=1. Required: r1_ready is 1 for one cycle; rsp_valid=1 two cycles later with rsp_data=0xBEEF, rsp_id=1, rsp_last=1.
- Burst: r0_addr=10, r0_len=3, storage[10..13]=0x100..0x103. Required: 4 beats with data 0x100 through 0x103 at 2-cycle spacing, rsp_id=0, rsp_last only on 0x103.
- Wrap: r0_addr=1022, r0_len=2. Required: beats read addresses 1022, 1023 and 0, in that order.
- Tie and round-robin: both requesters valid continuously after reset. Grant order is 0, 1, 0, 1. r1_ready is never high while r0_ready is high.
- Back-pressure: rsp_ready=0 for 5 cycles in the middle of a burst. Required: rsp outputs stay constant, no beat is lost or duplicated, and the burst completes after the stall.
- Reset mid-burst: assert reset during beat 2 of a 16-beat burst. Required: rsp_valid=0 and busy=0 immediately; after release, r1 alone is granted with the IDLE latency.
